// File: rtl/quad_uart_arb_pkg.sv
// Shared types, default widths and the round-robin pick helper for quad_uart_wb_arbiter.
package quad_uart_arb_pkg;

  localparam int DEF_NUM_MASTERS = 4;
  localparam int DEF_ADR_W       = 32;
  localparam int DEF_DAT_W       = 32;
  localparam int DEF_TIMEOUT     = 255;
  localparam int RR_MAX          = 8;

  typedef enum logic {ARB_IDLE, ARB_OWN} arb_state_e;

  // First requester at or after ptr, wrapping modulo n; one-hot result, 0 if nobody asks.
  function automatic logic [RR_MAX-1:0] rr_pick(input logic [RR_MAX-1:0] req,
                                                input logic [2:0]        ptr,
                                                input int unsigned       n);
    logic [RR_MAX-1:0] g;
    logic              found;
    int unsigned       idx;
    g     = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < RR_MAX; i++) begin
      idx = (32'(ptr) + i) % n;
      if (i < n && !found && req[idx[2:0]]) begin
        g[idx[2:0]] = 1'b1;
        found       = 1'b1;
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/quad_uart_wb_arbiter_if.sv
// Bus bundle between the requesting masters, the arbiter and the quad_uart_top slave port.
interface quad_uart_wb_arbiter_if
  import quad_uart_arb_pkg::*;
#(
  parameter int NUM_MASTERS = DEF_NUM_MASTERS,
  parameter int ADR_W       = DEF_ADR_W,
  parameter int DAT_W       = DEF_DAT_W
) ();

  logic [NUM_MASTERS-1:0]                m_cyc_i;
  logic [NUM_MASTERS-1:0]                m_stb_i;
  logic [NUM_MASTERS-1:0]                m_we_i;
  logic [NUM_MASTERS-1:0][ADR_W-1:0]     m_adr_i;
  logic [NUM_MASTERS-1:0][DAT_W-1:0]     m_dat_i;
  logic [NUM_MASTERS-1:0][DAT_W/8-1:0]   m_sel_i;
  logic [DAT_W-1:0]                      m_dat_o;
  logic [NUM_MASTERS-1:0]                m_ack_o;
  logic [NUM_MASTERS-1:0]                m_err_o;
  logic [NUM_MASTERS-1:0]                gnt_o;

  logic                                  s_cyc_o;
  logic                                  s_stb_o;
  logic                                  s_we_o;
  logic [ADR_W-1:0]                      s_adr_o;
  logic [DAT_W-1:0]                      s_dat_o;
  logic [DAT_W/8-1:0]                    s_sel_o;
  logic [DAT_W-1:0]                      s_dat_i;
  logic                                  s_ack_i;

  // Arbiter side.
  modport slave (
    input  m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i, s_dat_i, s_ack_i,
    output m_dat_o, m_ack_o, m_err_o, gnt_o,
           s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o
  );

  // Masters plus the downstream slave, as seen from outside the arbiter.
  modport master (
    output m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i, s_dat_i, s_ack_i,
    input  m_dat_o, m_ack_o, m_err_o, gnt_o,
           s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o
  );

endinterface

// File: rtl/quad_uart_arb_rr.sv
// Combinational round-robin selector: one-hot grant for the first requester at/after ptr.
module quad_uart_arb_rr
  import quad_uart_arb_pkg::*;
#(
  parameter int N     = DEF_NUM_MASTERS,
  parameter int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt
);

  assign gnt = N'(rr_pick(RR_MAX'(req), 3'(ptr), N));

endmodule

// File: rtl/quad_uart_wb_arbiter.sv
// Round-robin Wishbone arbiter in front of quad_uart_top; the grant is held for a whole CYC tenure.
// Optional ack timeout with error termination: define QUAD_UART_ARB_TIMEOUT_EN.
module quad_uart_wb_arbiter
  import quad_uart_arb_pkg::*;
#(
  parameter int NUM_MASTERS    = DEF_NUM_MASTERS,
  parameter int ADR_W          = DEF_ADR_W,
  parameter int DAT_W          = DEF_DAT_W,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  quad_uart_wb_arbiter_if.slave bus
);

  localparam int PTR_W = $clog2(NUM_MASTERS);
  localparam int SEL_W = DAT_W / 8;

  if (NUM_MASTERS < 2 || NUM_MASTERS > RR_MAX || TIMEOUT_CYCLES < 1) begin : g_cfg_err
    $error("quad_uart_wb_arbiter: unsupported parameter set");
  end

  arb_state_e             state_q, state_d;
  logic [NUM_MASTERS-1:0] gnt_q, gnt_d, pick;
  logic [PTR_W-1:0]       ptr_q, ptr_d, gnt_idx;
  logic                   own_cyc, stb_raw, to_hit;

  quad_uart_arb_rr #(.N(NUM_MASTERS), .PTR_W(PTR_W)) u_rr (
    .req (bus.m_cyc_i),
    .ptr (ptr_q),
    .gnt (pick)
  );

  always_comb begin
    gnt_idx = '0;
    for (int k = 0; k < NUM_MASTERS; k++)
      if (gnt_q[k]) gnt_idx = PTR_W'(k);
  end

  assign own_cyc = |(bus.m_cyc_i & gnt_q);
  assign stb_raw = |(bus.m_stb_i & gnt_q);

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state_q <= ARB_IDLE;
      gnt_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    case (state_q)
      ARB_IDLE: if (|bus.m_cyc_i) begin
        state_d = ARB_OWN;
        gnt_d   = pick;
      end
      ARB_OWN: if (!own_cyc) begin
        // Owner released: fall back to IDLE for one dead cycle, next owner is the one after it.
        state_d = ARB_IDLE;
        gnt_d   = '0;
        ptr_d   = (gnt_idx == PTR_W'(NUM_MASTERS - 1)) ? '0 : gnt_idx + 1'b1;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

`ifdef QUAD_UART_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt;

  // Hit depends only on the registered count, so forcing STB low here cannot loop back.
  assign to_hit = (state_q == ARB_OWN) && stb_raw && (to_cnt == TO_W'(TIMEOUT_CYCLES));

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i)                                                      to_cnt <= '0;
    else if (state_q != ARB_OWN || !stb_raw || bus.s_ack_i || to_hit) to_cnt <= '0;
    else                                                                to_cnt <= to_cnt + 1'b1;
  end

  assign bus.m_err_o = to_hit ? gnt_q : '0;
`else
  assign to_hit      = 1'b0;
  assign bus.m_err_o = '0;
`endif

  logic             mux_we;
  logic [ADR_W-1:0] mux_adr;
  logic [DAT_W-1:0] mux_dat;
  logic [SEL_W-1:0] mux_sel;

  always_comb begin
    mux_we  = 1'b0;
    mux_adr = '0;
    mux_dat = '0;
    mux_sel = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (gnt_q[k]) begin
        mux_we  = bus.m_we_i[k];
        mux_adr = bus.m_adr_i[k];
        mux_dat = bus.m_dat_i[k];
        mux_sel = bus.m_sel_i[k];
      end
    end
  end

  assign bus.s_cyc_o = own_cyc;
  assign bus.s_stb_o = stb_raw & ~to_hit;
  assign bus.s_we_o  = mux_we;
  assign bus.s_adr_o = mux_adr;
  assign bus.s_dat_o = mux_dat;
  assign bus.s_sel_o = mux_sel;
  assign bus.gnt_o   = gnt_q;
  assign bus.m_ack_o = {NUM_MASTERS{bus.s_ack_i}} & gnt_q & bus.m_stb_i;
  assign bus.m_dat_o = bus.s_dat_i;

endmodule

// File: tb/tb_quad_uart_wb_arbiter.sv
// Self-checking bench for quad_uart_wb_arbiter: vector table, scoreboard and multi-cycle sequences.
module tb_quad_uart_wb_arbiter;

  typedef struct {
    logic [31:0] adr;
    logic [31:0] dat;
    logic        we;
    logic [3:0]  sel;
  } sb_t;

  typedef struct {
    int          mst;
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [3:0]  exp_gnt;
    logic [31:0] exp_rd;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  logic ack_en;
  always #5 clk = ~clk;

  logic        cyc_r [4];
  logic        stb_r [4];
  logic        we_r  [4];
  logic [31:0] adr_r [4];
  logic [31:0] dat_r [4];
  logic [3:0]  sel_r [4];

  int  n_tests = 0;
  int  n_fail  = 0;
  sb_t exp_q [4][$];
  int  ord_q [$];
  int  idle_cnt, bad_switch;
  logic [3:0] prev_gnt;

  quad_uart_wb_arbiter_if #(.NUM_MASTERS(4), .ADR_W(32), .DAT_W(32)) bus ();

  quad_uart_wb_arbiter #(.NUM_MASTERS(4), .ADR_W(32), .DAT_W(32), .TIMEOUT_CYCLES(8)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst_n),
    .bus      (bus)
  );

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      bus.m_cyc_i[k] = cyc_r[k];
      bus.m_stb_i[k] = stb_r[k];
      bus.m_we_i[k]  = we_r[k];
      bus.m_adr_i[k] = adr_r[k];
      bus.m_dat_i[k] = dat_r[k];
      bus.m_sel_i[k] = sel_r[k];
    end
  end

  // Zero-wait slave: acks any strobe in the same cycle, read data is the inverted address.
  assign bus.s_ack_i = ack_en & bus.s_cyc_o & bus.s_stb_o;
  assign bus.s_dat_i = ~bus.s_adr_o;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Scoreboard: the master id lives in adr[31:28], so the acked master is known independently of gnt_o.
  always @(negedge clk) begin
    int          k;
    sb_t         e;
    logic [31:0] rexp;
    if (rst_n && bus.s_cyc_o && bus.s_stb_o && bus.s_ack_i) begin
      k = int'(bus.s_adr_o[31:28]);
      ord_q.push_back(k);
      if (k > 3 || exp_q[k].size() == 0) begin
        chk("sb_unexpected_adr", bus.s_adr_o, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        e    = exp_q[k].pop_front();
        rexp = ~e.adr;
        chk("sb_gnt", bus.gnt_o, 64'(1) << k);
        chk("sb_ack", bus.m_ack_o, 64'(1) << k);
        chk("sb_adr", bus.s_adr_o, e.adr);
        chk("sb_we", bus.s_we_o, e.we);
        chk("sb_sel", bus.s_sel_o, e.sel);
        if (e.we) chk("sb_wdat", bus.s_dat_o, e.dat);
        chk("sb_rdat", bus.m_dat_o, rexp);
      end
    end
  end

  always @(negedge clk) begin
    if (bus.gnt_o == 4'b0 && bus.m_cyc_i != 4'b0) idle_cnt++;
    if (prev_gnt != 4'b0 && bus.gnt_o != 4'b0 && prev_gnt != bus.gnt_o) bad_switch++;
    prev_gnt = bus.gnt_o;
  end

  task automatic xfer(input int k, input logic we, input logic [31:0] adr, input logic [3:0] sel,
                      input int nph, output logic [3:0] g, output logic [31:0] rd);
    sb_t  e;
    int   t;
    logic got;
    g  = '0;
    rd = '0;
    @(posedge clk); #1;
    cyc_r[k] = 1'b1; stb_r[k] = 1'b1; we_r[k] = we; sel_r[k] = sel;
    for (int p = 0; p < nph; p++) begin
      adr_r[k] = adr + 32'(p * 4);
      dat_r[k] = adr_r[k] ^ 32'h00A5_5A00;
      e.adr = adr_r[k]; e.dat = dat_r[k]; e.we = we; e.sel = sel;
      exp_q[k].push_back(e);
      t = 0; got = 1'b0;
      while (!got && t < 100) begin
        @(negedge clk);
        t++;
        got = bus.m_ack_o[k];
      end
      chk($sformatf("xfer_ack_m%0d", k), got, 1'b1);
      g  = bus.gnt_o;
      rd = bus.m_dat_o;
      @(posedge clk); #1;
    end
    cyc_r[k] = 1'b0; stb_r[k] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_order(input string name, input int exp[$]);
    chk({name, "_len"}, ord_q.size(), exp.size());
    for (int i = 0; i < exp.size() && i < ord_q.size(); i++)
      chk($sformatf("%s_%0d", name, i), ord_q[i], exp[i]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs [4];
    logic [3:0]  g;
    logic [31:0] rd;
    int          cnt, errs;
    logic [3:0]  errv;
    logic        stbv;

    vecs[0] = '{mst: 2, we: 1'b0, adr: 32'h2000_0010, sel: 4'hF, exp_gnt: 4'b0100, exp_rd: 32'hDFFF_FFEF};
    vecs[1] = '{mst: 0, we: 1'b1, adr: 32'h0000_0040, sel: 4'h3, exp_gnt: 4'b0001, exp_rd: 32'hFFFF_FFBF};
    vecs[2] = '{mst: 3, we: 1'b0, adr: 32'h3000_0004, sel: 4'hC, exp_gnt: 4'b1000, exp_rd: 32'hCFFF_FFFB};
    vecs[3] = '{mst: 1, we: 1'b1, adr: 32'h1000_0ABC, sel: 4'h1, exp_gnt: 4'b0010, exp_rd: 32'hEFFF_F543};

    for (int k = 0; k < 4; k++) begin
      cyc_r[k] = 1'b1; stb_r[k] = 1'b1; we_r[k] = 1'b0;
      adr_r[k] = '0; dat_r[k] = '0; sel_r[k] = '0;
    end
    ack_en = 1'b1; rst_n = 1'b0; prev_gnt = '0;

    // Reset state with every master requesting.
    #3;
    chk("rst_gnt", bus.gnt_o, 4'b0);
    chk("rst_scyc", bus.s_cyc_o, 1'b0);
    chk("rst_sstb", bus.s_stb_o, 1'b0);
    chk("rst_ack", bus.m_ack_o, 4'b0);
    chk("rst_err", bus.m_err_o, 4'b0);
    chk("rst_mdat", bus.m_dat_o, 32'hFFFF_FFFF);
    for (int k = 0; k < 4; k++) begin cyc_r[k] = 1'b0; stb_r[k] = 1'b0; end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2);

    // All four request: 0,1,2,3 then 0 again, one idle cycle before each grant.
    ord_q.delete(); idle_cnt = 0; bad_switch = 0;
    fork
      begin
        xfer(0, 1'b1, 32'h0000_0100, 4'hF, 1, g, rd);
        xfer(0, 1'b1, 32'h0000_0104, 4'hF, 1, g, rd);
      end
      xfer(1, 1'b1, 32'h1000_0100, 4'hF, 1, g, rd);
      xfer(2, 1'b1, 32'h2000_0100, 4'hF, 1, g, rd);
      xfer(3, 1'b1, 32'h3000_0100, 4'hF, 1, g, rd);
    join
    idle(2);
    chk_order("rr_order", '{0, 1, 2, 3, 0});
    chk("rr_idle_cycles", idle_cnt, 5);
    chk("rr_direct_switch", bad_switch, 0);

    // Master 1 burst of three STB phases; master 0 waits until CYC drops.
    ord_q.delete(); idle_cnt = 0; bad_switch = 0;
    fork
      xfer(1, 1'b0, 32'h1000_0200, 4'hF, 3, g, rd);
      begin
        @(posedge clk);
        xfer(0, 1'b1, 32'h0000_0200, 4'hF, 1, g, rd);
      end
    join
    idle(2);
    chk_order("burst_order", '{1, 1, 1, 0});
    chk("burst_idle_cycles", idle_cnt, 2);
    chk("burst_direct_switch", bad_switch, 0);

    // Grant latency for a lone master 2 with the slave stalled one cycle.
    ack_en = 1'b0;
    @(posedge clk); #1;
    cyc_r[2] = 1'b1; stb_r[2] = 1'b1; we_r[2] = 1'b0; sel_r[2] = 4'hF; adr_r[2] = 32'h2000_0010;
    exp_q[2].push_back('{adr: 32'h2000_0010, dat: dat_r[2], we: 1'b0, sel: 4'hF});
    @(negedge clk);
    chk("lat_scyc_early", bus.s_cyc_o, 1'b0);
    chk("lat_gnt_early", bus.gnt_o, 4'b0);
    @(negedge clk);
    chk("lat_scyc", bus.s_cyc_o, 1'b1);
    chk("lat_gnt", bus.gnt_o, 4'b0100);
    chk("lat_noack", bus.m_ack_o, 4'b0);
    @(posedge clk); #1 ack_en = 1'b1;
    @(negedge clk);
    chk("lat_ack", bus.m_ack_o, 4'b0100);
    chk("lat_mdat", bus.m_dat_o, 32'hDFFF_FFEF);
    @(posedge clk); #1 cyc_r[2] = 1'b0; stb_r[2] = 1'b0;
    idle(2);

    // Single requesters from whatever pointer position the previous owner left.
    for (int i = 0; i < 4; i++) begin
      xfer(vecs[i].mst, vecs[i].we, vecs[i].adr, vecs[i].sel, 1, g, rd);
      chk($sformatf("vec%0d_gnt", i), g, vecs[i].exp_gnt);
      chk($sformatf("vec%0d_rd", i), rd, vecs[i].exp_rd);
      idle(1);
    end

    // Pointer now 2: masters 1 and 3 together, 3 wins first.
    ord_q.delete();
    fork
      xfer(1, 1'b1, 32'h1000_0300, 4'hF, 1, g, rd);
      xfer(3, 1'b1, 32'h3000_0300, 4'hF, 1, g, rd);
    join
    idle(2);
    chk_order("ptr2_order", '{3, 1});

    // Reset while master 2 waits for an ack; afterwards the pointer restarts at master 0.
    ack_en = 1'b0;
    @(posedge clk); #1;
    cyc_r[2] = 1'b1; stb_r[2] = 1'b1; adr_r[2] = 32'h2000_0400;
    cyc_r[0] = 1'b1; stb_r[0] = 1'b1; adr_r[0] = 32'h0000_0400;
    idle(2);
    chk("mid_gnt_before", bus.gnt_o, 4'b0100);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_gnt", bus.gnt_o, 4'b0);
    chk("mid_rst_scyc", bus.s_cyc_o, 1'b0);
    chk("mid_rst_ack", bus.m_ack_o, 4'b0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_idle", bus.gnt_o, 4'b0);
    @(negedge clk);
    chk("post_rst_gnt", bus.gnt_o, 4'b0001);
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) begin cyc_r[k] = 1'b0; stb_r[k] = 1'b0; end
    idle(3);

    // Unacked access: error termination when enabled, endless wait otherwise.
    @(posedge clk); #1;
    cyc_r[0] = 1'b1; stb_r[0] = 1'b1; adr_r[0] = 32'h0000_0500;
`ifdef QUAD_UART_ARB_TIMEOUT_EN
    cnt = 0; errv = '0; stbv = 1'b1;
    for (int c = 0; c < 40 && errv == 4'b0; c++) begin
      @(negedge clk);
      if (bus.m_err_o != 4'b0) begin
        errv = bus.m_err_o;
        stbv = bus.s_stb_o;
      end else if (bus.s_stb_o) cnt++;
    end
    chk("to_err", errv, 4'b0001);
    chk("to_strobed_cycles", cnt, 8);
    chk("to_stb_forced_low", stbv, 1'b0);
    @(negedge clk);
    chk("to_err_one_cycle", bus.m_err_o, 4'b0);
    chk("to_gnt_kept", bus.gnt_o, 4'b0001);
    chk("to_restrobe", bus.s_stb_o, 1'b1);
`else
    errs = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.m_err_o != 4'b0) errs++;
    end
    chk("no_err_without_timeout", errs, 0);
    chk("wait_gnt_held", bus.gnt_o, 4'b0001);
    chk("wait_stb_held", bus.s_stb_o, 1'b1);
`endif
    @(posedge clk); #1 cyc_r[0] = 1'b0; stb_r[0] = 1'b0; ack_en = 1'b1;
    idle(3);

    chk("sb_drained", exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
